// File: rtl/tag_access_pkg.sv
// Shared types for the cache tag access controller: line states, FSM states, address width helper.
// TAG_ACCESS_CONTROLLER_WRITEBACK_EN selects write-back/write-allocate; otherwise write-through.
package tag_access_pkg;

  typedef logic [1:0] line_state_t;

  localparam line_state_t INVALID = 2'd0;
  localparam line_state_t VALID   = 2'd1;
`ifdef TAG_ACCESS_CONTROLLER_WRITEBACK_EN
  localparam line_state_t DIRTY   = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
`ifdef TAG_ACCESS_CONTROLLER_WRITEBACK_EN
    S_WRITEBACK,
`else
    S_WRITETHROUGH,
`endif
    S_FILL,
    S_UPDATE,
    S_RESPOND
  } fsm_state_t;

  function automatic int address_width(input int tag_width, input int index_width,
                                       input int offset_width);
    return tag_width + index_width + offset_width;
  endfunction

endpackage

// File: rtl/tag_access_controller_memory_request_port.sv
// Memory bus request port: holds memRequest/memWrite/memAddress from start until memAck.
// A start in the ack cycle re-arms the request without a gap (writeback -> fill).
module memory_request_port #(
  parameter int ADDRESS_WIDTH = 26
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     start_write,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic                     memAck,
  output logic                     memRequest,
  output logic                     memWrite,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  output logic                     done
);

  assign done = memRequest & memAck;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memRequest <= 1'b0;
      memWrite   <= 1'b0;
      memAddress <= '0;
    end else if (start) begin
      memRequest <= 1'b1;
      memWrite   <= start_write;
      memAddress <= start_address;
    end else if (done) begin
      memRequest <= 1'b0;
      memWrite   <= 1'b0;
    end
  end

endmodule

// File: rtl/tag_access_controller.sv
// Cache tag access sequencer for one CPU port: lookup, optional victim writeback, fill, tag update.
// TAG_ACCESS_CONTROLLER_WRITEBACK_EN selects write-back/write-allocate; default is write-through.
//
// state          | meaning
// S_IDLE         | waiting for cpuRequest, request captured on accept
// S_LOOKUP       | tag unit compares stored tag at the captured index
// S_WRITEBACK    | dirty victim line written to memory (write-back build)
// S_WRITETHROUGH | write forwarded to memory, no allocate (write-through build)
// S_FILL         | line read from memory
// S_UPDATE       | new tag and line state written
// S_RESPOND      | one-cycle cpuDone
module tag_access_controller
  import tag_access_pkg::*;
#(
  parameter int TAG_WIDTH    = 16,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  localparam int ADDRESS_WIDTH = address_width(TAG_WIDTH, INDEX_WIDTH, OFFSET_WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpuRequest,
  input  logic                     cpuWrite,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
  output logic                     cpuDone,
  output logic [INDEX_WIDTH-1:0]   tagIndex,
  output logic [TAG_WIDTH-1:0]     tagTagIn,
  input  logic [TAG_WIDTH-1:0]     tagTagOut,
  input  logic [1:0]               tagStateOut,
  input  logic                     tagHit,
  output logic                     tagWriteTag,
  output logic                     tagWriteState,
  output logic [1:0]               tagStateIn,
  output logic                     memRequest,
  output logic                     memWrite,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  input  logic                     memAck
);

  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    {{(TAG_WIDTH + INDEX_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  fsm_state_t               state, state_next;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic                     req_write;
  logic                     lookup_hit;
  logic                     mem_start, mem_start_write, mem_done;
  logic [ADDRESS_WIDTH-1:0] mem_start_address;

  assign tagIndex = req_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tagTagIn = req_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];

  // Qualify tagHit against the stored tag/state so a stale hit cannot skip a fill.
  assign lookup_hit = tagHit && (tagTagOut == tagTagIn) && (tagStateOut != INVALID);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_address <= '0;
      req_write   <= 1'b0;
    end else if (state == S_IDLE && cpuRequest) begin
      req_address <= cpuAddress;
      req_write   <= cpuWrite;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    mem_start         = 1'b0;
    mem_start_write   = 1'b0;
    mem_start_address = req_address & LINE_MASK;
    case (state)
      S_IDLE: if (cpuRequest) state_next = S_LOOKUP;
`ifdef TAG_ACCESS_CONTROLLER_WRITEBACK_EN
      S_LOOKUP: begin
        if (lookup_hit) begin
          state_next = S_RESPOND;
        end else if (tagStateOut == DIRTY) begin
          state_next        = S_WRITEBACK;
          mem_start         = 1'b1;
          mem_start_write   = 1'b1;
          mem_start_address = {tagTagOut, tagIndex, {OFFSET_WIDTH{1'b0}}};
        end else begin
          state_next = S_FILL;
          mem_start  = 1'b1;
        end
      end
      S_WRITEBACK: if (mem_done) begin
        state_next = S_FILL;
        mem_start  = 1'b1;
      end
`else
      S_LOOKUP: begin
        if (req_write) begin
          state_next      = S_WRITETHROUGH;
          mem_start       = 1'b1;
          mem_start_write = 1'b1;
        end else if (lookup_hit) begin
          state_next = S_RESPOND;
        end else begin
          state_next = S_FILL;
          mem_start  = 1'b1;
        end
      end
      S_WRITETHROUGH: if (mem_done) state_next = S_RESPOND;
`endif
      S_FILL:    if (mem_done) state_next = S_UPDATE;
      S_UPDATE:  state_next = S_RESPOND;
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpuDone       = (state == S_RESPOND);
    tagWriteTag   = 1'b0;
    tagWriteState = 1'b0;
    tagStateIn    = INVALID;
    case (state)
`ifdef TAG_ACCESS_CONTROLLER_WRITEBACK_EN
      S_LOOKUP: if (lookup_hit && req_write) begin
        tagWriteState = 1'b1;
        tagStateIn    = DIRTY;
      end
`endif
      S_UPDATE: begin
        tagWriteTag   = 1'b1;
        tagWriteState = 1'b1;
        tagStateIn    = VALID;
`ifdef TAG_ACCESS_CONTROLLER_WRITEBACK_EN
        if (req_write) tagStateIn = DIRTY;
`endif
      end
      default: ;
    endcase
  end

  memory_request_port #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_memory_request_port (
    .clock        (clock),
    .reset        (reset),
    .start        (mem_start),
    .start_write  (mem_start_write),
    .start_address(mem_start_address),
    .memAck       (memAck),
    .memRequest   (memRequest),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .done         (mem_done)
  );

endmodule

// File: tb/tb_tag_access_controller.sv
// Directed bench for tag_access_controller with a behavioural tag unit and an acking memory.
// Expectations follow the build selected by TAG_ACCESS_CONTROLLER_WRITEBACK_EN.
module tb_tag_access_controller;
  localparam int TW = 16, IW = 6, OW = 4, AW = 26;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpuRequest = 1'b0, cpuWrite = 1'b0, memAck = 1'b0;
  logic [AW-1:0] cpuAddress = '0;
  logic          cpuDone, tagWriteTag, tagWriteState, tagHit, memRequest, memWrite;
  logic [IW-1:0] tagIndex;
  logic [TW-1:0] tagTagIn, tagTagOut;
  logic [1:0]    tagStateOut, tagStateIn;
  logic [AW-1:0] memAddress;

  always #5 clock = ~clock;

  tag_access_controller #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)) dut (
    .clock(clock), .reset(reset), .cpuRequest(cpuRequest), .cpuWrite(cpuWrite),
    .cpuAddress(cpuAddress), .cpuDone(cpuDone), .tagIndex(tagIndex), .tagTagIn(tagTagIn),
    .tagTagOut(tagTagOut), .tagStateOut(tagStateOut), .tagHit(tagHit),
    .tagWriteTag(tagWriteTag), .tagWriteState(tagWriteState), .tagStateIn(tagStateIn),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress), .memAck(memAck)
  );

  // Behavioural tag unit: combinational lookup, clocked writes.
  logic [TW-1:0] tag_mem [64];
  logic [1:0]    st_mem  [64];
  logic          clear_mem = 1'b1;

  assign tagTagOut   = tag_mem[tagIndex];
  assign tagStateOut = st_mem[tagIndex];
  assign tagHit      = (tag_mem[tagIndex] == tagTagIn) && (st_mem[tagIndex] != 2'd0);

  always @(posedge clock) begin
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) begin
        tag_mem[i] <= '0;
        st_mem[i]  <= '0;
      end
    end else begin
      if (tagWriteTag)   tag_mem[tagIndex] <= tagTagIn;
      if (tagWriteState) st_mem[tagIndex]  <= tagStateIn;
    end
  end

  typedef struct {
    logic          wr;
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [OW-1:0] off;
    int            dly;
    int            lat;
    int            nmem;
    logic          fw;
    logic [AW-1:0] fa;
    logic          lw;
    logic [AW-1:0] la;
    int            rises;
    logic [1:0]    st;
    logic [TW-1:0] ftag;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(logic wr, logic [TW-1:0] tag, logic [IW-1:0] idx, logic [OW-1:0] off,
                              int dly, int lat, int nmem, logic fw, logic [TW-1:0] ft,
                              logic lw, logic [TW-1:0] lt, int rises, logic [1:0] st,
                              logic [TW-1:0] ftag);
    vec_t v;
    v.wr = wr; v.tag = tag; v.idx = idx; v.off = off; v.dly = dly; v.lat = lat;
    v.nmem = nmem; v.fw = fw; v.lw = lw; v.rises = rises; v.st = st; v.ftag = ftag;
    v.fa = (nmem == 0) ? '0 : {ft, idx, 4'h0};
    v.la = (nmem == 0) ? '0 : {lt, idx, 4'h0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one access, acks each memory transfer after v.dly waiting cycles, records what was seen.
  task automatic apply_vec(input vec_t v, input int n);
    int lat, nmem, rises, wait_cnt, extra;
    logic fw, lw, prev_req, done;
    logic [AW-1:0] fa, la;
    lat = -1; nmem = 0; rises = 0; wait_cnt = 0; extra = 0;
    fw = 0; lw = 0; fa = '0; la = '0; prev_req = 0; done = 0;
    cpuRequest = 1'b1;
    cpuWrite   = v.wr;
    cpuAddress = {v.tag, v.idx, v.off};
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clock); #1;
      if (memRequest && !prev_req) rises++;
      prev_req = memRequest;
      if (cpuDone) begin
        lat = c;
        done = 1'b1;
        cpuRequest = 1'b0;
      end
      if (memRequest) begin
        if (wait_cnt == v.dly) begin
          memAck = 1'b1;
          if (nmem == 0) begin fw = memWrite; fa = memAddress; end
          lw = memWrite;
          la = memAddress;
          nmem++;
          wait_cnt = 0;
        end else begin
          memAck = 1'b0;
          wait_cnt++;
        end
      end else begin
        memAck = 1'b0;
        wait_cnt = 0;
      end
    end
    cpuRequest = 1'b0;
    memAck = 1'b0;
    @(posedge clock); #1;
    if (cpuDone) extra = 1;
    check($sformatf("v%0d_latency", n), lat, v.lat);
    check($sformatf("v%0d_mem_count", n), nmem, v.nmem);
    check($sformatf("v%0d_first_write", n), {31'd0, fw}, {31'd0, v.fw});
    check($sformatf("v%0d_first_addr", n), {6'd0, fa}, {6'd0, v.fa});
    check($sformatf("v%0d_last_write", n), {31'd0, lw}, {31'd0, v.lw});
    check($sformatf("v%0d_last_addr", n), {6'd0, la}, {6'd0, v.la});
    check($sformatf("v%0d_req_rises", n), rises, v.rises);
    check($sformatf("v%0d_repeat_done", n), extra, 0);
    check($sformatf("v%0d_line_state", n), {30'd0, st_mem[v.idx]}, {30'd0, v.st});
    check($sformatf("v%0d_line_tag", n), {16'd0, tag_mem[v.idx]}, {16'd0, v.ftag});
  endtask

  initial begin
    int seen;
`ifdef TAG_ACCESS_CONTROLLER_WRITEBACK_EN
    vecs.push_back(mk(0, 16'h0001, 6'h23, 4'h0, 2, 6, 1, 0, 16'h0001, 0, 16'h0001, 1, 2'd1, 16'h0001));
    vecs.push_back(mk(0, 16'h0001, 6'h23, 4'h4, 0, 2, 0, 0, 16'h0000, 0, 16'h0000, 0, 2'd1, 16'h0001));
    vecs.push_back(mk(1, 16'h0001, 6'h23, 4'h8, 1, 2, 0, 0, 16'h0000, 0, 16'h0000, 0, 2'd2, 16'h0001));
    vecs.push_back(mk(0, 16'h0002, 6'h23, 4'h0, 1, 7, 2, 1, 16'h0001, 0, 16'h0002, 1, 2'd1, 16'h0002));
    vecs.push_back(mk(1, 16'h0003, 6'h10, 4'h0, 0, 4, 1, 0, 16'h0003, 0, 16'h0003, 1, 2'd2, 16'h0003));
    vecs.push_back(mk(0, 16'h0001, 6'h10, 4'h0, 0, 5, 2, 1, 16'h0003, 0, 16'h0001, 1, 2'd1, 16'h0001));
`else
    vecs.push_back(mk(0, 16'h0001, 6'h23, 4'h0, 2, 6, 1, 0, 16'h0001, 0, 16'h0001, 1, 2'd1, 16'h0001));
    vecs.push_back(mk(0, 16'h0001, 6'h23, 4'h4, 0, 2, 0, 0, 16'h0000, 0, 16'h0000, 0, 2'd1, 16'h0001));
    vecs.push_back(mk(1, 16'h0001, 6'h23, 4'h8, 1, 4, 1, 1, 16'h0001, 1, 16'h0001, 1, 2'd1, 16'h0001));
    vecs.push_back(mk(1, 16'h0002, 6'h23, 4'h5, 0, 3, 1, 1, 16'h0002, 1, 16'h0002, 1, 2'd1, 16'h0001));
    vecs.push_back(mk(0, 16'h0002, 6'h23, 4'hF, 0, 4, 1, 0, 16'h0002, 0, 16'h0002, 1, 2'd1, 16'h0002));
    vecs.push_back(mk(0, 16'h0003, 6'h3F, 4'h0, 3, 7, 1, 0, 16'h0003, 0, 16'h0003, 1, 2'd1, 16'h0003));
    vecs.push_back(mk(0, 16'hFFFF, 6'h00, 4'h1, 1, 5, 1, 0, 16'hFFFF, 0, 16'hFFFF, 1, 2'd1, 16'hFFFF));
`endif

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_cpuDone", {31'd0, cpuDone}, 0);
    check("rst_memRequest", {31'd0, memRequest}, 0);
    check("rst_memWrite", {31'd0, memWrite}, 0);
    check("rst_memAddress", {6'd0, memAddress}, 0);
    check("rst_tagWriteTag", {31'd0, tagWriteTag}, 0);
    check("rst_tagWriteState", {31'd0, tagWriteState}, 0);
    check("rst_tagStateIn", {30'd0, tagStateIn}, 0);
    check("rst_tagIndex", {26'd0, tagIndex}, 0);
    check("rst_tagTagIn", {16'd0, tagTagIn}, 0);
    clear_mem = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Reset while a fill is outstanding: request drops at once and no completion follows.
    cpuRequest = 1'b1;
    cpuWrite   = 1'b0;
    cpuAddress = {16'h0007, 6'h05, 4'h0};
    memAck     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("abort_req_before", {31'd0, memRequest}, 1);
    check("abort_write_before", {31'd0, memWrite}, 0);
    reset = 1'b0;
    #1;
    check("abort_req_dropped", {31'd0, memRequest}, 0);
    check("abort_no_done", {31'd0, cpuDone}, 0);
    cpuRequest = 1'b0;
    @(posedge clock); #1;
    check("abort_no_done_later", {31'd0, cpuDone}, 0);
    check("abort_line_untouched", {30'd0, st_mem[5]}, 0);
    @(negedge clock);
    reset = 1'b1;
    apply_vec(mk(0, 16'h0007, 6'h05, 4'h0, 1, 5, 1, 0, 16'h0007, 0, 16'h0007, 1, 2'd1, 16'h0007), 90);

    // cpuRequest withdrawn after acceptance: the hit still completes.
    cpuRequest = 1'b1;
    cpuWrite   = 1'b0;
    cpuAddress = {16'h0007, 6'h05, 4'h3};
    @(posedge clock); #1;
    cpuRequest = 1'b0;
    seen = -1;
    for (int c = 2; c <= 10 && seen < 0; c++) begin
      @(posedge clock); #1;
      if (cpuDone) seen = c;
    end
    check("drop_request_done_cycle", seen, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
